// File: rtl/up_dn_cmd_ctrl.sv
// Command front-end for up_dn_counter: synchronises and debounces raw
// buttons, queues one pending command per button and issues load > up > down
// as single-cycle pulses, with up/down gated by the counter's high/low flags.
// Ports: CLK, RST (async active-low); load_btn/up_btn/down_btn raw buttons;
//        IN_sw load switches; high/low counter flags; IN registered load
//        value; load/up/down command pulses; reject pulse for a dropped step.
module up_dn_cmd_ctrl #(
    parameter int DATA_W    = 5,
    parameter int DB_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_btn,
    input  logic              up_btn,
    input  logic              down_btn,
    input  logic [DATA_W-1:0] IN_sw,
    input  logic              high,
    input  logic              low,
    output logic [DATA_W-1:0] IN,
    output logic              load,
    output logic              up,
    output logic              down,
    output logic              reject
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Bit 0 = load, bit 1 = up, bit 2 = down throughout.
    logic [2:0]          s1_q, s1_d;
    logic [2:0]          s2_q, s2_d;
    logic [2:0]          db_q, db_d;
    logic [2:0]          db_dly_q, db_dly_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic [2:0]          pend_q, pend_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   in_q, in_d;
    logic                load_q, load_d;
    logic                up_q, up_d;
    logic                down_q, down_d;
    logic                reject_q, reject_d;
    logic [2:0]          press;
    logic [2:0]          clr;

    always_comb begin
        s1_d     = {down_btn, up_btn, load_btn};
        s2_d     = s1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            // Count only while the synced input disagrees; any bounce
            // back to the current level restarts the count.
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        press = db_q & ~db_dly_q;

        clr      = '0;
        load_d   = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
        reject_d = 1'b0;
        in_d     = in_q;
        priority case (1'b1)
            pend_q[0]: begin
                load_d = 1'b1;
                in_d   = shadow_q;
                clr[0] = 1'b1;
            end
            pend_q[1]: begin
                clr[1]   = 1'b1;
                up_d     = ~high;
                reject_d = high;
            end
            pend_q[2]: begin
                clr[2]   = 1'b1;
                down_d   = ~low;
                reject_d = low;
            end
            default: ;
        endcase

        // A press landing on the clearing edge stays pending.
        pend_d   = (pend_q & ~clr) | press;
        shadow_d = press[0] ? IN_sw : shadow_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            shadow_q <= '0;
            in_q     <= '0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            in_q     <= in_d;
            load_q   <= load_d;
            up_q     <= up_d;
            down_q   <= down_d;
            reject_q <= reject_d;
        end
    end

    assign IN     = in_q;
    assign load   = load_q;
    assign up     = up_q;
    assign down   = down_q;
    assign reject = reject_q;

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Bench for up_dn_cmd_ctrl: directed steps plus random button traffic,
// compared each cycle with a behavioural model and a simple counter.
module tb_up_dn_cmd_ctrl;

    localparam int DW = 5;
    localparam int DB = 4;
    localparam int MAXV = 31;

    logic          CLK = 1'b0;
    logic          RST;
    logic          load_btn, up_btn, down_btn;
    logic [DW-1:0] IN_sw;
    logic          high, low;
    logic [DW-1:0] IN;
    logic          load, up, down, reject;

    int cnt = 0;
    assign high = (cnt == MAXV);
    assign low  = (cnt == 0);

    up_dn_cmd_ctrl #(.DATA_W(DW), .DB_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST),
        .load_btn(load_btn), .up_btn(up_btn), .down_btn(down_btn),
        .IN_sw(IN_sw), .high(high), .low(low),
        .IN(IN), .load(load), .up(up), .down(down), .reject(reject)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int n_load = 0, n_up = 0, n_down = 0, n_rej = 0;

    // Behavioural model state
    logic [2:0]    m_s1, m_s2, m_db, m_prev;
    int            m_run [3];
    logic [2:0]    m_pend;
    logic [DW-1:0] m_shadow, m_in;
    logic          m_load, m_up, m_down, m_rej;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_pend = '0; m_shadow = '0; m_in = '0;
        m_load = 0; m_up = 0; m_down = 0; m_rej = 0;
    endtask

    // One clock edge of the reference behaviour, from pre-edge values.
    task automatic model_step();
        logic [2:0] raw, pressed;
        if (!RST) begin
            model_clear();
            return;
        end
        raw = {down_btn, up_btn, load_btn};
        pressed = m_db & ~m_prev;
        m_load = 0; m_up = 0; m_down = 0; m_rej = 0;
        if (m_pend[0]) begin
            m_load = 1; m_in = m_shadow; m_pend[0] = 0;
        end else if (m_pend[1]) begin
            m_pend[1] = 0;
            if (high) m_rej = 1; else m_up = 1;
        end else if (m_pend[2]) begin
            m_pend[2] = 0;
            if (low) m_rej = 1; else m_down = 1;
        end
        m_pend = m_pend | pressed;
        if (pressed[0]) m_shadow = IN_sw;
        m_prev = m_db;
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Called around a negedge: model, edge, counter update, compare.
    task automatic tick();
        int nxt;
        model_step();
        nxt = cnt;
        if (load) nxt = int'(IN);
        else if (up && cnt < MAXV) nxt = cnt + 1;
        else if (down && cnt > 0) nxt = cnt - 1;
        @(posedge CLK);
        #1 cnt = nxt;
        @(negedge CLK);
        chk("IN", int'(IN), int'(m_in));
        chk("load", int'(load), int'(m_load));
        chk("up", int'(up), int'(m_up));
        chk("down", int'(down), int'(m_down));
        chk("reject", int'(reject), int'(m_rej));
        chk("excl", int'(($countones({load, up, down}) <= 1)
                         && !(reject && (up || down))), 1);
        n_load += int'(load);
        n_up   += int'(up);
        n_down += int'(down);
        n_rej  += int'(reject);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int t_load, t_up, t_down, cnt_at_down, b_up, b_down, b_rej;

    initial begin
        RST = 1'b0;
        load_btn = 0; up_btn = 0; down_btn = 0;
        IN_sw = '0;
        model_clear();
        @(negedge CLK);
        hold(3);
        chk("rst_IN", int'(IN), 0);
        chk("rst_pulses", int'({load, up, down, reject}), 0);
        RST = 1'b1;
        hold(3);

        // Single load: pulse on the 8th edge from E0
        IN_sw = 10;
        load_btn = 1;
        t_load = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (load && t_load == 0) t_load = k;
        end
        chk("load_lat", t_load, DB + 4);
        load_btn = 0;
        hold(10);
        chk("load_IN_hold", int'(IN), 10);
        chk("load_cnt", cnt, 10);
        chk("load_once", n_load, 1);

        // Short glitch is filtered, a real press steps once
        b_up = n_up;
        up_btn = 1; hold(3);
        up_btn = 0; hold(12);
        chk("glitch_up", n_up - b_up, 0);
        chk("glitch_cnt", cnt, 10);
        up_btn = 1; hold(10);
        up_btn = 0; hold(10);
        chk("press_up", n_up - b_up, 1);
        chk("press_cnt", cnt, 11);

        // Simultaneous presses issue load, up, down on consecutive cycles
        IN_sw = 3;
        load_btn = 1; up_btn = 1; down_btn = 1;
        t_load = 0; t_up = 0; t_down = 0; cnt_at_down = -1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (load && t_load == 0) t_load = k;
            if (up && t_up == 0) t_up = k;
            if (down && t_down == 0) begin
                t_down = k;
                cnt_at_down = cnt;
            end
        end
        load_btn = 0; up_btn = 0; down_btn = 0;
        hold(12);
        chk("sim_load_t", t_load, DB + 4);
        chk("sim_up_t", t_up, DB + 5);
        chk("sim_down_t", t_down, DB + 6);
        chk("sim_cnt_mid", cnt_at_down, 4);
        chk("sim_cnt_end", cnt, 3);

        // Saturation at max and at zero
        IN_sw = 31;
        load_btn = 1; hold(10);
        load_btn = 0; hold(10);
        chk("sat_hi_cnt0", cnt, 31);
        b_up = n_up; b_rej = n_rej;
        up_btn = 1; hold(10);
        up_btn = 0; hold(10);
        chk("sat_hi_up", n_up - b_up, 0);
        chk("sat_hi_rej", n_rej - b_rej, 1);
        chk("sat_hi_cnt", cnt, 31);
        IN_sw = 0;
        load_btn = 1; hold(10);
        load_btn = 0; hold(10);
        b_down = n_down; b_rej = n_rej;
        down_btn = 1; hold(10);
        down_btn = 0; hold(10);
        chk("sat_lo_down", n_down - b_down, 0);
        chk("sat_lo_rej", n_rej - b_rej, 1);
        chk("sat_lo_cnt", cnt, 0);

        // Long hold gives one pulse; re-press gives another
        b_up = n_up;
        up_btn = 1; hold(200);
        chk("held_once", n_up - b_up, 1);
        up_btn = 0; hold(10);
        up_btn = 1; hold(10);
        up_btn = 0; hold(10);
        chk("held_repress", n_up - b_up, 2);
        chk("held_cnt", cnt, 2);

        // Async reset with up still pending behind a load
        IN_sw = 7;
        load_btn = 1; up_btn = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (load) break;
        end
        chk("rst_pre_load", int'(load), 1);
        RST = 1'b0;
        #1;
        chk("rst_async_load", int'(load), 0);
        chk("rst_async_up", int'(up), 0);
        chk("rst_async_IN", int'(IN), 0);
        model_clear();
        load_btn = 0; up_btn = 0;
        hold(2);
        RST = 1'b1;
        b_up = n_up;
        hold(15);
        chk("rst_no_up", n_up - b_up, 0);
        chk("rst_IN_after", int'(IN), 0);

        // Random bouncy traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(5) == 0) load_btn = ~load_btn;
            if ($urandom_range(5) == 0) up_btn = ~up_btn;
            if ($urandom_range(5) == 0) down_btn = ~down_btn;
            if ($urandom_range(7) == 0) IN_sw = DW'($urandom);
            tick();
        end
        load_btn = 0; up_btn = 0; down_btn = 0;
        hold(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_dn_cmd_ctrl.md
Name: up_dn_cmd_ctrl

Overview:
Command front-end that sits directly upstream of up_dn_counter and drives its IN, load, up and down inputs. It synchronises and debounces raw pushbutton/switch inputs, and turns each debounced press into exactly one single-cycle command pulse. Commands are arbitrated and queued, and up/down are gated against the counter's high/low flags so the counter never sees a step past its limits.

Parameters:
DATA_W, 5, width of load value (matches counter width)
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=2)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
load_btn  in  1  raw load button, asynchronous to CLK
up_btn  in  1  raw up button, asynchronous to CLK
down_btn  in  1  raw down button, asynchronous to CLK
IN_sw  in  DATA_W  load value switches, quasi-static
high  in  1  counter-at-max flag from up_dn_counter
low  in  1  counter-at-zero flag from up_dn_counter
IN  out  DATA_W  registered load value to counter
load  out  1  one-cycle load command
up  out  1  one-cycle increment command
down  out  1  one-cycle decrement command
reject  out  1  one-cycle pulse when a queued up/down is dropped due to high/low

Behaviour:
- Reset: one clock, async active-low. RST=0 immediately clears every output (IN=0, load=up=down=reject=0) and all internal state: sync FFs, debounced levels, debounce counters, pending flags. Operation resumes on the first rising edge with RST=1.
- Synchroniser: two FFs per button. s1 samples raw at edge k; s2 holds it after edge k+1.
- Debounce, per button, with counter width clog2(DB_CYCLES):
  - If s2 != db: if cnt == DB_CYCLES-1, then db<=s2 and cnt<=0; else cnt<=cnt+1.
  - If s2 == db: cnt<=0. Any bounce restarts the count.
- Edge detect: press = db & ~db_d, where db_d is db delayed one cycle. Releases generate nothing.
- Pending flags pend_load, pend_up, pend_down:
  - Set on the edge where the matching press=1.
  - On that same edge pend_load captures IN_sw into an internal shadow register.
  - Each flag holds until it is issued or dropped. A repeated press while a flag is pending is absorbed (no double count).
- Issue stage, evaluated every edge:
  - Priority: load > up > down. At most one command per cycle; the others stay pending.
  - Load issue: load<=1, IN<=shadow, clear pend_load. IN holds its value until the next load issue.
  - Up issue when high=0: up<=1, clear pend_up.
  - Up when high=1: up stays 0, reject<=1, clear pend_up.
  - Down issue when low=0: down<=1, clear pend_down.
  - Down when low=1: down stays 0, reject<=1, clear pend_down.
  - A new press arriving on the same edge its flag is cleared is kept: set wins over clear.
  - load, up, down and reject are registered and deasserted on the following edge, so each is a one-cycle pulse.
- Mutual exclusion: load, up and down are never high together. reject never coincides with up or down.
- Latency: raw held stable from before sampling edge E0 gives:
  - db flips at E0+DB_CYCLES+1
  - pending set at E0+DB_CYCLES+2
  - command pulse high for the cycle after E0+DB_CYCLES+3, if no higher-priority command is pending.
- High/low are sampled at the issue edge. The one-cycle gap between pulses lets the counter's flags update before the next step.

Test Plan:
- Reset: RST=0 mid-operation with pend_up set -> all outputs 0 at once. After release no up pulse appears and IN=0.
- Single load: IN_sw=10, load_btn held from before E0 (DB_CYCLES=4) -> load=1 and IN=10 for exactly the cycle after E0+7. IN stays 10 afterwards.
- Debounce reject: up_btn glitches high for 3 cycles then low -> no up pulse, counter unchanged. Held 4+ cycles -> exactly one up pulse; counter 10->11.
- Simultaneous presses: load (IN_sw=3), up and down debounced on the same edge -> pulses issue on consecutive cycles in order load, up, down. Counter goes 3, 4, 3.
- Saturation: counter at 31 (high=1), up press -> no up pulse, reject=1 for one cycle, counter stays 31. Same for down at 0 with low=1.
- Held button: up_btn held for 200 cycles -> exactly one up pulse. Release and re-press -> a second pulse.
